bn_demux_1_8_reg: RTL and testbench
===================================

Name: bn_demux_1_8_reg

Overview:
- Registered 1-to-8 one-hot demultiplexer with a valid/ready stream on every side.
- Routes one input stream word to one of eight output channels, picked by a one-hot sel.
- Each channel has a one-entry holding register, giving 1 cycle of latency and per-channel backpressure.
- Sits downstream of producers that feed the lab's 8-to-1 one-hot selector family, and handles the opposite direction: one source to many sinks.

Parameters:
- DATA_WIDTH, 8: width of each data word.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the input word is valid.
- in_ready  output  1  the block accepts the input word this cycle.
- in_data  input  DATA_WIDTH  input word.
- sel  input  8  one-hot target channel; bit k selects channel k.
- out_valid  output  8  bit k: channel k holds a word.
- out_ready  input  8  bit k: the sink of channel k takes the word this cycle.
- out_data  output  8*DATA_WIDTH  packed channel words; channel k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- err  output  1  one-cycle pulse: the previous transfer had a non-one-hot sel.
- drop_cnt  output  8  saturating count of discarded transfers.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - out_valid = 0, out_data = 0, err = 0, drop_cnt = 0.
  - All slot contents are discarded, including any in flight.
- Handshake rules:
  - An input transfer happens when in_valid & in_ready.
  - A channel-k pop happens when out_valid[k] & out_ready[k].
- sel_ok = sel is exactly one-hot (popcount == 1).
- in_ready (combinational from sel, slot state and out_ready):
  - If sel_ok and sel[k]=1: in_ready = ~out_valid[k] | out_ready[k].
  - If !sel_ok: in_ready = 1, so upstream never hangs.
- Valid transfer to channel k:
  - Next cycle out_valid[k]=1 and slice k = the captured in_data.
  - Latency is exactly 1 cycle.
- Simultaneous pop and push on the same channel: the slice is replaced by the new word and out_valid[k] stays 1. No bubble, no loss.
- Pop with no push: out_valid[k] -> 0. The slice keeps its last value and is not cleared.
- Word held with out_ready[k]=0: the slice and out_valid[k] stay stable until popped.
- Channels are independent: pushes go to one channel while pops happen on any number of channels in the same cycle.
- Invalid transfer (!sel_ok, including sel=0 and multi-hot):
  - The word is discarded and no out_valid bit changes.
  - err = 1 on the next cycle only.
  - drop_cnt increments, saturating at 255 (no wrap).
- sel and in_data are sampled only at the transfer edge; changes without in_valid have no effect.
- out_valid, out_data, err and drop_cnt are all registered outputs.

Decomposition:
- Package bn_demux_pkg holds:
  - N_CH = 8 and DROP_MAX = 8'd255.
  - Function is_onehot(sel) returning 1 when the popcount is 1.
- Sub-module bn_slot_reg: one-entry holding register.
  - Ports: clk, rst, push, pop, d, q, full.
  - Instantiated N_CH times via generate.
- Top level holds sel decode, in_ready generation and the err/drop_cnt logic.

Test Plan:
- Reset check: rst=1 mid-run with channels 0 and 5 full -> out_valid=8'h00 and out_data=0 before the next clk edge. After release, in_ready=1 and drop_cnt=0.
- Walking one:
  - Stimulus: sel=8'b00000001 shifted left 7 times, in_data=0..7, out_ready=8'hFF, in_valid=1.
  - Required: out_valid[k] high 1 cycle after each push, slice k = k, all other valid bits 0.
- Backpressure:
  - Push 123 to sel=8'b00000100 with out_ready[2]=0, then push 77 with the same sel: in_ready=0 and slice 2 stays 123.
  - Raise out_ready[2]: 123 pops and 77 is captured in the same cycle, then 77 pops on the next cycle.
- Invalid sel:
  - Transfers with sel=8'h00 and then 8'b00000011 -> in_ready=1, out_valid unchanged.
  - err pulses once after each transfer; drop_cnt goes 1 then 2.
- Saturation: 300 consecutive transfers with sel=8'h00 -> drop_cnt=255 and holds. A valid push afterwards still routes correctly.
- Parallel traffic: channels 1 and 6 full with out_ready=8'b01000010 while pushing to channel 3 -> both pop, channel 3 fills, no data corruption.

Source files
------------

// File: rtl/bn_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bn_demux_pkg
// Brief    : Shared constants and helpers for the 1-to-8 registered demux.
// Revision : 1.0
// ============================================================================
package bn_demux_pkg;

    localparam int unsigned N_CH     = 8;
    localparam logic [7:0]  DROP_MAX = 8'd255;

    function automatic logic is_onehot(input logic [N_CH-1:0] sel);
        return ($countones(sel) == 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bn_slot_reg.sv
`default_nettype none
// ============================================================================
// Module   : bn_slot_reg
// Brief    : One-entry holding register with push/pop and a full flag.
// Revision : 1.0
// ============================================================================
module bn_slot_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_full;

    // A push wins over a pop so a same-cycle pop/push replaces the word without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_full <= 1'b0;
        end else if (push) begin
            r_q    <= d;
            r_full <= 1'b1;
        end else if (pop) begin
            r_full <= 1'b0;
        end
    end

    assign q    = r_q;
    assign full = r_full;

endmodule
`default_nettype wire

// File: rtl/bn_demux_1_8_reg.sv
`default_nettype none
// ============================================================================
// Module   : bn_demux_1_8_reg
// Brief    : Registered 1-to-8 one-hot demux with per-channel valid/ready slots.
// Revision : 1.0
// ============================================================================
module bn_demux_1_8_reg
    import bn_demux_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [N_CH-1:0]            sel,
    output logic [N_CH-1:0]            out_valid,
    input  logic [N_CH-1:0]            out_ready,
    output logic [N_CH*DATA_WIDTH-1:0] out_data,
    output logic                       err,
    output logic [7:0]                 drop_cnt
);

    logic            w_sel_ok;
    logic            w_xfer;
    logic            w_drop;
    logic [N_CH-1:0] w_room;
    logic [N_CH-1:0] w_push;
    logic [N_CH-1:0] w_pop;
    logic            r_err;
    logic [7:0]      r_drop_cnt;

    assign w_sel_ok = is_onehot(sel);
    assign w_room   = sel & (~out_valid | out_ready);

    // Malformed selects are always accepted and dropped so the producer never stalls.
    assign in_ready = w_sel_ok ? (|w_room) : 1'b1;
    assign w_xfer   = in_valid & in_ready;
    assign w_drop   = w_xfer & ~w_sel_ok;
    assign w_push   = (w_xfer & w_sel_ok) ? sel : '0;
    assign w_pop    = out_valid & out_ready;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_slot
            bn_slot_reg #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_slot (
                .clk  (clk),
                .rst  (rst),
                .push (w_push[k]),
                .pop  (w_pop[k]),
                .d    (in_data),
                .q    (out_data[k*DATA_WIDTH +: DATA_WIDTH]),
                .full (out_valid[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_err <= w_drop;
            if (w_drop && (r_drop_cnt != DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign err      = r_err;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bn_demux_1_8_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_bn_demux_1_8_reg
// Brief    : Scoreboard bench for the registered 1-to-8 one-hot demux.
// Revision : 1.0
// ============================================================================
module tb_bn_demux_1_8_reg;

    localparam int DW = 8;

    typedef struct {
        int         ch;
        logic [7:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [7:0]    sel;
    logic [7:0]    out_valid;
    logic [7:0]    out_ready;
    logic [8*DW-1:0] out_data;
    logic          err;
    logic [7:0]    drop_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   m_drop = 0;

    bn_demux_1_8_reg #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int ch, input logic [7:0] d);
        exp_t e;
        e.ch   = ch;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drop_step();
        m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
    endtask

    // Every pop seen on any channel is matched against the oldest expected word for that channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (idx < 0 && exp_q[i].ch == k) idx = i;
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL pop_unexpected ch%0d: got data %0d, expected no word", k, out_data[k*DW +: DW]);
                    end else begin
                        if (out_data[k*DW +: DW] !== exp_q[idx].data) begin
                            errors++;
                            $display("FAIL pop_data ch%0d: got %0d, expected %0d", k, out_data[k*DW +: DW], exp_q[idx].data);
                        end
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        out_ready = 8'h00;
        in_valid  = 1'b1;
        sel       = 8'h01;
        in_data   = 8'hA0;
        push_exp(0, 8'hA0);
        tick();
        sel     = 8'h20;
        in_data = 8'hA5;
        push_exp(5, 8'hA5);
        tick();
        in_valid = 1'b0;
        #2;
        checks++;
        if (out_valid !== 8'h21) begin
            errors++;
            $display("FAIL pre_reset_valid: got %h, expected 21", out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 8'h00 || out_data !== '0 || err !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%h data=%h err=%b drop=%0d, expected all zero", out_valid, out_data, err, drop_cnt);
        end
        exp_q.delete();
        m_drop = 0;
        tick();
        tick();
        rst = 1'b0;
        sel = 8'h01;
        #1;
        checks++;
        if (in_ready !== 1'b1 || drop_cnt !== 8'd0 || out_valid !== 8'h00) begin
            errors++;
            $display("FAIL post_reset: in_ready=%b drop=%0d valid=%h, expected 1/0/00", in_ready, drop_cnt, out_valid);
        end
    endtask

    task automatic test_walking_one();
        logic [7:0] exp_v;
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sel     = 8'h01 << k;
            in_data = 8'(k);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL walk_ready ch%0d: got %b, expected 1", k, in_ready);
            end
            push_exp(k, 8'(k));
            tick();
            exp_v = 8'h01 << k;
            checks++;
            if (out_valid !== exp_v || out_data[k*DW +: DW] !== 8'(k)) begin
                errors++;
                $display("FAIL walk_out ch%0d: valid=%h data=%0d, expected valid=%h data=%0d", k, out_valid, out_data[k*DW +: DW], exp_v, k);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 8'h00) begin
            errors++;
            $display("FAIL walk_drain: got %h, expected 00", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 8'h00;
        sel       = 8'b0000_0100;
        in_data   = 8'd123;
        in_valid  = 1'b1;
        #1;
        push_exp(2, 8'd123);
        tick();
        in_data = 8'd77;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low: got %b, expected 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 8'h04 || out_data[2*DW +: DW] !== 8'd123) begin
            errors++;
            $display("FAIL bp_hold: valid=%h data=%0d, expected 04/123", out_valid, out_data[2*DW +: DW]);
        end
        out_ready = 8'h04;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_release: got %b, expected 1", in_ready);
        end
        push_exp(2, 8'd77);
        tick();
        checks++;
        if (out_valid !== 8'h04 || out_data[2*DW +: DW] !== 8'd77) begin
            errors++;
            $display("FAIL bp_replace: valid=%h data=%0d, expected 04/77", out_valid, out_data[2*DW +: DW]);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 8'h00 || out_data[2*DW +: DW] !== 8'd77) begin
            errors++;
            $display("FAIL bp_pop_keep: valid=%h data=%0d, expected 00/77", out_valid, out_data[2*DW +: DW]);
        end
        out_ready = 8'h00;
    endtask

    task automatic test_invalid_sel();
        sel      = 8'h10;
        in_data  = 8'h44;
        in_valid = 1'b1;
        push_exp(4, 8'h44);
        tick();
        sel     = 8'h00;
        in_data = 8'hEE;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL inv_ready_zero: got %b, expected 1", in_ready);
        end
        drop_step();
        tick();
        checks++;
        if (err !== 1'b1 || drop_cnt !== 8'(m_drop) || out_valid !== 8'h10) begin
            errors++;
            $display("FAIL inv_zero: err=%b drop=%0d valid=%h, expected 1/%0d/10", err, drop_cnt, out_valid, m_drop);
        end
        sel = 8'b0000_0011;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL inv_ready_multi: got %b, expected 1", in_ready);
        end
        drop_step();
        tick();
        checks++;
        if (err !== 1'b1 || drop_cnt !== 8'd2 || out_valid !== 8'h10) begin
            errors++;
            $display("FAIL inv_multi: err=%b drop=%0d valid=%h, expected 1/2/10", err, drop_cnt, out_valid);
        end
        in_valid = 1'b0;
        sel      = 8'h00;
        tick();
        checks++;
        if (err !== 1'b0 || drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL inv_pulse_end: err=%b drop=%0d, expected 0/2", err, drop_cnt);
        end
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;
    endtask

    task automatic test_saturation();
        sel      = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drop_step();
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (drop_cnt !== 8'd255 || m_drop != 255 || err !== 1'b0) begin
            errors++;
            $display("FAIL sat_count: drop=%0d err=%b, expected 255/0", drop_cnt, err);
        end
        sel       = 8'h80;
        in_data   = 8'h5A;
        in_valid  = 1'b1;
        push_exp(7, 8'h5A);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 8'h80 || out_data[7*DW +: DW] !== 8'h5A || drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_route: valid=%h data=%h drop=%0d, expected 80/5a/255", out_valid, out_data[7*DW +: DW], drop_cnt);
        end
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;
    endtask

    task automatic test_parallel();
        in_valid = 1'b1;
        sel      = 8'h02;
        in_data  = 8'h11;
        push_exp(1, 8'h11);
        tick();
        sel     = 8'h40;
        in_data = 8'h66;
        push_exp(6, 8'h66);
        tick();
        out_ready = 8'b0100_0010;
        sel       = 8'h08;
        in_data   = 8'h33;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL par_ready: got %b, expected 1", in_ready);
        end
        push_exp(3, 8'h33);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 8'h08 || out_data[3*DW +: DW] !== 8'h33 ||
            out_data[1*DW +: DW] !== 8'h11 || out_data[6*DW +: DW] !== 8'h66) begin
            errors++;
            $display("FAIL par_state: valid=%h data=%h, expected valid=08 ch3=33 ch1=11 ch6=66", out_valid, out_data);
        end
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;
    endtask

    task automatic test_back_to_back();
        out_ready = 8'hFF;
        sel       = 8'h20;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hC0 + 8'(i);
            push_exp(5, 8'hC0 + 8'(i));
            tick();
            checks++;
            if (out_valid !== 8'h20 || out_data[5*DW +: DW] !== 8'hC0 + 8'(i)) begin
                errors++;
                $display("FAIL b2b_%0d: valid=%h data=%h, expected 20/%h", i, out_valid, out_data[5*DW +: DW], 8'hC0 + 8'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 8'h00;
        checks++;
        if (out_valid !== 8'h00 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: valid=%h pending=%0d, expected 00/0", out_valid, exp_q.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        sel       = 8'h00;
        out_ready = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_walking_one();
        test_backpressure();
        test_invalid_sel();
        test_saturation();
        test_parallel();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
